// File: rtl/z_bus_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : z_bus_rx_if
//  Brief    : Valid/ready handshake carrying accepted z bus values downstream.
//  Revision : 1.0 - initial release
// ============================================================================
interface z_bus_rx_if #(
    parameter int DATA_W = 4
);
    logic              z_valid;
    logic              z_ready;
    logic [DATA_W-1:0] z_data;

    // Producer side: the receiver presents values and watches ready
    modport master (output z_valid, output z_data, input z_ready);
    // Consumer side: downstream logic takes values and drives ready
    modport slave  (input z_valid, input z_data, output z_ready);
endinterface
`default_nettype wire

// File: rtl/z_bus_rx.sv
`default_nettype none
// ============================================================================
//  Module   : z_bus_rx
//  Brief    : Strobe-less asynchronous z bus receiver. Synchronizes the bus,
//             accepts a value once it has been stable long enough, and offers
//             it on a valid/ready handshake. Debug: update counter, settle
//             time of the last update and a sticky overrun flag.
//  Revision : 1.0 - initial release
// ============================================================================
module z_bus_rx #(
    parameter int DATA_W        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [DATA_W-1:0] z_async,
    input  wire logic              en,
    z_bus_rx_if.master             zb,
    output logic      [CNT_W-1:0]  update_count,
    output logic      [CNT_W-1:0]  settle_cycles,
    output logic                   overrun
);

    // Stable-run counter only needs to reach STABLE_CYCLES-1
    localparam int                 C_SC_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) + 1 : 1;
    localparam logic [C_SC_W-1:0]  C_LAST    = C_SC_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_CNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
    logic [DATA_W-1:0]                  z_sync;

    state_t              state_q,         state_d;
    logic [DATA_W-1:0]   ref_val_q,       ref_val_d;
    logic [DATA_W-1:0]   cand_q,          cand_d;
    logic [C_SC_W-1:0]   stable_cnt_q,    stable_cnt_d;
    logic [CNT_W-1:0]    elapsed_q,       elapsed_d;
    logic                z_valid_q,       z_valid_d;
    logic [DATA_W-1:0]   z_data_q,        z_data_d;
    logic [CNT_W-1:0]    update_count_q,  update_count_d;
    logic [CNT_W-1:0]    settle_cycles_q, settle_cycles_d;
    logic                overrun_q,       overrun_d;

    logic                accept;
    logic [DATA_W-1:0]   accept_val;
    logic [CNT_W-1:0]    accept_settle;
    logic [CNT_W-1:0]    elapsed_inc;

    assign z_sync      = sync_q[SYNC_STAGES-1];
    assign elapsed_inc = (elapsed_q == C_CNT_MAX) ? elapsed_q : elapsed_q + 1'b1;

    // Synchronizer chain; runs independent of en so the bus is always current
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], z_async};
        end
    end

    // Settle FSM next-state plus accept/handshake bookkeeping
    always_comb begin
        state_d         = state_q;
        ref_val_d       = ref_val_q;
        cand_d          = cand_q;
        stable_cnt_d    = stable_cnt_q;
        elapsed_d       = elapsed_q;
        accept          = 1'b0;
        accept_val      = cand_q;
        accept_settle   = elapsed_inc;
        z_data_d        = z_data_q;
        update_count_d  = update_count_q;
        settle_cycles_d = settle_cycles_q;
        overrun_d       = overrun_q;
        // A pending value drops once the consumer takes it
        z_valid_d       = z_valid_q && !zb.z_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (en && (z_sync != ref_val_q)) begin
                    if (STABLE_CYCLES == 1) begin
                        // One sample is already enough: accept on the spot
                        accept        = 1'b1;
                        accept_val    = z_sync;
                        accept_settle = CNT_W'(1);
                    end else begin
                        cand_d       = z_sync;
                        stable_cnt_d = C_SC_W'(1);
                        elapsed_d    = CNT_W'(1);
                        state_d      = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                elapsed_d = elapsed_inc;
                if (!en) begin
                    state_d      = ST_IDLE;
                    stable_cnt_d = '0;
                    elapsed_d    = '0;
                end else if ((z_sync == cand_q) && (stable_cnt_q == C_LAST)) begin
                    accept       = 1'b1;
                    accept_val   = cand_q;
                    state_d      = ST_IDLE;
                    stable_cnt_d = '0;
                    elapsed_d    = '0;
                end else if (z_sync == cand_q) begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                end else if (z_sync == ref_val_q) begin
                    // Bus bounced back to the accepted value: a glitch
                    state_d      = ST_IDLE;
                    stable_cnt_d = '0;
                    elapsed_d    = '0;
                end else begin
                    cand_d       = z_sync;
                    stable_cnt_d = C_SC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            ref_val_d       = accept_val;
            z_data_d        = accept_val;
            z_valid_d       = 1'b1;
            update_count_d  = update_count_q + 1'b1;
            settle_cycles_d = accept_settle;
            // Previous value was still waiting and is now lost
            if (z_valid_q && !zb.z_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            ref_val_q       <= '0;
            cand_q          <= '0;
            stable_cnt_q    <= '0;
            elapsed_q       <= '0;
            z_valid_q       <= 1'b0;
            z_data_q        <= '0;
            update_count_q  <= '0;
            settle_cycles_q <= '0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            ref_val_q       <= ref_val_d;
            cand_q          <= cand_d;
            stable_cnt_q    <= stable_cnt_d;
            elapsed_q       <= elapsed_d;
            z_valid_q       <= z_valid_d;
            z_data_q        <= z_data_d;
            update_count_q  <= update_count_d;
            settle_cycles_q <= settle_cycles_d;
            overrun_q       <= overrun_d;
        end
    end

    assign zb.z_valid    = z_valid_q;
    assign zb.z_data     = z_data_q;
    assign update_count  = update_count_q;
    assign settle_cycles = settle_cycles_q;
    assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_z_bus_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_z_bus_rx
//  Brief    : Self-checking bench for z_bus_rx: directed scenarios plus a
//             randomized phase, compared every cycle against a run-length
//             model of the receiver.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_z_bus_rx;

    localparam int DATA_W        = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 16;
    localparam int CNT_W         = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic [DATA_W-1:0] z_async = '0;
    logic [CNT_W-1:0]  update_count;
    logic [CNT_W-1:0]  settle_cycles;
    logic              overrun;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    z_bus_rx_if #(.DATA_W(DATA_W)) zb ();

    z_bus_rx #(
        .DATA_W        (DATA_W),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .z_async       (z_async),
        .en            (en),
        .zb            (zb),
        .update_count  (update_count),
        .settle_cycles (settle_cycles),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: the FSM sees the bus SYNC_STAGES edges late. A value is
    // accepted when, with en high, it has been seen on STABLE_CYCLES
    // consecutive edges and differs from the last accepted value. The
    // settle time is the length of the unbroken stretch of edges with en
    // high and bus != accepted value that ends in the accept.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] m_hist [SYNC_STAGES];
    logic [DATA_W-1:0] m_ref, m_data, m_runval, m_zs;
    logic              m_valid, m_overrun;
    logic [CNT_W-1:0]  m_cnt, m_settle;
    int                m_run, m_dev;
    bit                m_acc;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = '0;
            m_ref = '0; m_data = '0; m_runval = '0;
            m_valid = 1'b0; m_overrun = 1'b0;
            m_cnt = '0; m_settle = '0;
            m_run = 0; m_dev = 0;
        end else begin
            m_zs = m_hist[SYNC_STAGES-1];
            for (int i = SYNC_STAGES-1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = z_async;
            m_acc = 1'b0;
            if (en && (m_zs != m_ref)) begin
                m_dev = (m_dev < 65535) ? m_dev + 1 : 65535;
                if (m_run > 0 && m_zs == m_runval) m_run++;
                else begin
                    m_run    = 1;
                    m_runval = m_zs;
                end
                if (m_run == STABLE_CYCLES) m_acc = 1'b1;
            end else begin
                m_dev = 0;
                m_run = 0;
            end
            if (m_acc) begin
                if (m_valid && !zb.z_ready) m_overrun = 1'b1;
                m_valid  = 1'b1;
                m_data   = m_zs;
                m_ref    = m_zs;
                m_cnt    = m_cnt + 1'b1;
                m_settle = CNT_W'(m_dev);
                m_dev    = 0;
                m_run    = 0;
            end else if (m_valid && zb.z_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_z_valid",       32'(zb.z_valid),    32'(m_valid));
            check("cyc_z_data",        32'(zb.z_data),     32'(m_data));
            check("cyc_update_count",  32'(update_count),  32'(m_cnt));
            check("cyc_settle_cycles", 32'(settle_cycles), 32'(m_settle));
            check("cyc_overrun",       32'(overrun),       32'(m_overrun));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges (first edge after the call is 1) until z_valid is seen; -1 on timeout
    task automatic wait_valid(output int k);
        k = 0;
        while (1) begin
            @(posedge clk);
            #1;
            k++;
            if (zb.z_valid) break;
            if (k > 200) begin
                k = -1;
                break;
            end
        end
    endtask

    int k;
    int seen;

    initial begin
        zb.z_ready = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        en  = 1'b1;
        cmp_on = 1'b1;

        // Quiet bus after reset: nothing to report
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (zb.z_valid) seen++;
        end
        check("t1_no_valid", 32'(seen), 32'd0);
        check("t1_count", 32'(update_count), 32'd0);
        check("t1_overrun", 32'(overrun), 32'd0);

        // Clean change: latency, data, settle time, one-cycle pulse
        z_async = 4'hA;
        wait_valid(k);
        check("t2_latency", 32'(k - 1), 32'd17);
        check("t2_data", 32'(zb.z_data), 32'hA);
        check("t2_count", 32'(update_count), 32'd1);
        check("t2_settle", 32'(settle_cycles), 32'd16);
        tick(1);
        check("t2_pulse_end", 32'(zb.z_valid), 32'd0);
        tick(5);

        // Glitch back to the accepted value is rejected
        z_async = 4'h3; tick(5);
        z_async = 4'hA; tick(30);
        check("t3_glitch_count", 32'(update_count), 32'd1);
        // Candidate change mid-settle: settle covers both
        z_async = 4'h3; tick(5);
        z_async = 4'h5;
        wait_valid(k);
        check("t3_data", 32'(zb.z_data), 32'h5);
        check("t3_settle", 32'(settle_cycles), 32'd21);
        check("t3_count", 32'(update_count), 32'd2);
        tick(5);

        // Overrun while downstream stalls
        zb.z_ready = 1'b0;
        z_async = 4'h6; tick(40);
        z_async = 4'h7; tick(30);
        check("t4_data", 32'(zb.z_data), 32'h7);
        check("t4_valid", 32'(zb.z_valid), 32'd1);
        check("t4_overrun", 32'(overrun), 32'd1);
        check("t4_count", 32'(update_count), 32'd4);
        zb.z_ready = 1'b1;
        tick(1);
        check("t4_xfer_valid", 32'(zb.z_valid), 32'd0);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);

        // Disabled receiver ignores the bus, catches up when re-enabled
        en = 1'b0;
        z_async = 4'h9; tick(50);
        check("t5_dis_count", 32'(update_count), 32'd4);
        check("t5_dis_valid", 32'(zb.z_valid), 32'd0);
        en = 1'b1;
        wait_valid(k);
        check("t5_latency", 32'(k), 32'd16);
        check("t5_data", 32'(zb.z_data), 32'h9);
        check("t5_settle", 32'(settle_cycles), 32'd16);
        tick(5);

        // Reset in the middle of settling
        z_async = 4'hC; tick(12);
        rst = 1'b1; tick(1);
        check("t6_rst_valid", 32'(zb.z_valid), 32'd0);
        check("t6_rst_data", 32'(zb.z_data), 32'd0);
        check("t6_rst_count", 32'(update_count), 32'd0);
        check("t6_rst_settle", 32'(settle_cycles), 32'd0);
        check("t6_rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        wait_valid(k);
        check("t6_latency", 32'(k - 1), 32'd17);
        check("t6_data", 32'(zb.z_data), 32'hC);
        check("t6_count", 32'(update_count), 32'd1);
        tick(5);

        // Randomized bus, enable, ready and occasional reset
        for (int s = 0; s < 300; s++) begin
            int hold;
            z_async = DATA_W'($urandom_range(0, 15));
            hold = $urandom_range(1, 24);
            for (int c = 0; c < hold; c++) begin
                zb.z_ready = ($urandom_range(0, 9) < 7);
                en  = ($urandom_range(0, 19) != 0);
                rst = ($urandom_range(0, 199) == 0);
                tick(1);
            end
        end
        rst = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
